// File: rtl/clk_phase_gen.sv
// rtl/clk_phase_gen.sv - multi-phase CPU clock strobe generator with oscillator-stable gating
// Strobes are decoded combinationally from the registered phase and run state.
module clk_phase_gen #(
   parameter int PHASES        = 8,
   parameter int STABLE_CYCLES = 16,
   parameter int RESET_HOLD    = 2
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      OSC_ENA,
   input  logic                      CLK_ENA,
   output logic [$clog2(PHASES)-1:0] PHASE_IDX,
   output logic                      RUN,
   output logic                      CYCLE_START,
   output logic                      MAIN_CLK_P,
   output logic                      DATA_CLK_P,
   output logic                      ADR_CLK_P,
   output logic                      INC_CLK_P,
   output logic                      LATCH_CLK,
   output logic                      OSC_STABLE,
   output logic                      SYNC_RESET
);

   localparam int PW = $clog2(PHASES);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int HW = $clog2(RESET_HOLD + 1);

   localparam logic [PW-1:0] PH_LAST    = PW'(PHASES - 1);
   localparam logic [PW-1:0] PH_HALF    = PW'(PHASES / 2);
   localparam logic [PW-1:0] PH_QUARTER = PW'(PHASES / 4);
   localparam logic [PW-1:0] PH_3QUART  = PW'((3 * PHASES) / 4);

   typedef enum logic {STOPPED, RUNNING} state_t;

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] phase;
   logic [SW-1:0] stab_cnt;
   logic [HW-1:0] hold_cnt;
   logic          sync_rst;
   logic          stable;
   logic          wrap;

   assign stable = (stab_cnt == SW'(STABLE_CYCLES));
   assign wrap   = (state == RUNNING) && (phase == PH_LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= STOPPED;
      else
         state <= state_next;
   end

   // Stops happen only at the cycle boundary; losing the oscillator stops at once.
   always_comb begin
      state_next = state;
      if (!OSC_ENA) begin
         state_next = STOPPED;
      end else begin
         case (state)
            STOPPED: if (CLK_ENA && stable) state_next = RUNNING;
            RUNNING: if (wrap && (!CLK_ENA || !stable)) state_next = STOPPED;
            default: state_next = STOPPED;
         endcase
      end
   end

   always_comb begin
      RUN         = (state == RUNNING);
      CYCLE_START = 1'b0;
      MAIN_CLK_P  = 1'b0;
      ADR_CLK_P   = 1'b0;
      DATA_CLK_P  = 1'b0;
      INC_CLK_P   = 1'b0;
      LATCH_CLK   = 1'b0;
      if (state == RUNNING) begin
         CYCLE_START = (phase == '0);
         MAIN_CLK_P  = (phase < PH_HALF);
         ADR_CLK_P   = (phase >= PH_HALF);
         DATA_CLK_P  = (phase >= PH_QUARTER) && (phase < PH_3QUART);
         INC_CLK_P   = (phase == PH_LAST);
         LATCH_CLK   = (phase == PH_HALF);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         phase <= '0;
      else if (!OSC_ENA || (state != RUNNING) || wrap)
         phase <= '0;
      else
         phase <= phase + PW'(1);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         stab_cnt <= '0;
      else if (!OSC_ENA)
         stab_cnt <= '0;
      else if (!stable)
         stab_cnt <= stab_cnt + SW'(1);
   end

   // Hold count only progresses across uninterrupted cycles while SYNC_RESET is asserted.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         hold_cnt <= '0;
      else if (!OSC_ENA || !stable || (state != RUNNING))
         hold_cnt <= '0;
      else if (wrap && sync_rst)
         hold_cnt <= hold_cnt + HW'(1);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         sync_rst <= 1'b1;
      else if (!OSC_ENA)
         sync_rst <= 1'b1;
      else if (wrap && sync_rst && (hold_cnt == HW'(RESET_HOLD - 1)))
         sync_rst <= 1'b0;
   end

   assign PHASE_IDX  = phase;
   assign OSC_STABLE = stable;
   assign SYNC_RESET = sync_rst;

endmodule

// File: tb/tb_clk_phase_gen.sv
// tb/tb_clk_phase_gen.sv - directed testbench for clk_phase_gen (default and 4-phase configs)
module tb_clk_phase_gen;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst_a, osc_a, ena_a;
   logic [2:0] phase_a;
   logic       run_a, cs_a, main_a, data_a, adr_a, inc_a, latch_a, stable_a, sync_a;

   logic       rst_b, osc_b, ena_b;
   logic [1:0] phase_b;
   logic       run_b, cs_b, main_b, data_b, adr_b, inc_b, latch_b, stable_b, sync_b;

   int vectors     = 0;
   int miscompares = 0;

   // {MAIN, DATA, ADR, INC, LATCH, CYCLE_START} per phase
   logic [5:0] tbl8 [0:7] = '{6'b100001, 6'b100000, 6'b110000, 6'b110000,
                              6'b011010, 6'b011000, 6'b001000, 6'b001100};
   logic [5:0] tbl4 [0:3] = '{6'b100001, 6'b110000, 6'b011010, 6'b001100};

   clk_phase_gen dut_a (
      .CLK(CLK), .RESET(rst_a), .OSC_ENA(osc_a), .CLK_ENA(ena_a),
      .PHASE_IDX(phase_a), .RUN(run_a), .CYCLE_START(cs_a),
      .MAIN_CLK_P(main_a), .DATA_CLK_P(data_a), .ADR_CLK_P(adr_a),
      .INC_CLK_P(inc_a), .LATCH_CLK(latch_a),
      .OSC_STABLE(stable_a), .SYNC_RESET(sync_a)
   );

   clk_phase_gen #(.PHASES(4), .STABLE_CYCLES(1), .RESET_HOLD(1)) dut_b (
      .CLK(CLK), .RESET(rst_b), .OSC_ENA(osc_b), .CLK_ENA(ena_b),
      .PHASE_IDX(phase_b), .RUN(run_b), .CYCLE_START(cs_b),
      .MAIN_CLK_P(main_b), .DATA_CLK_P(data_b), .ADR_CLK_P(adr_b),
      .INC_CLK_P(inc_b), .LATCH_CLK(latch_b),
      .OSC_STABLE(stable_b), .SYNC_RESET(sync_b)
   );

   function automatic logic [11:0] st_a();
      return {phase_a, run_a, stable_a, sync_a, main_a, data_a, adr_a, inc_a, latch_a, cs_a};
   endfunction

   function automatic logic [10:0] st_b();
      return {phase_b, run_b, stable_b, sync_b, main_b, data_b, adr_b, inc_b, latch_b, cs_b};
   endfunction

   function automatic logic [11:0] exp_a(logic [2:0] p, logic r, logic s, logic y);
      return {p, r, s, y, r ? tbl8[p] : 6'b0};
   endfunction

   function automatic logic [10:0] exp_b(logic [1:0] p, logic r, logic s, logic y);
      return {p, r, s, y, r ? tbl4[p] : 6'b0};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic startup_sequence(input string tag);
      logic [11:0] e;
      for (int i = 1; i <= 16; i++) begin
         tick();
         e = exp_a(3'd0, 1'b0, (i == 16), 1'b1);
         vectors++;
         if (st_a() !== e) begin
            miscompares++;
            $display("FAIL %s_stab edge %0d: got %h expected %h", tag, i, st_a(), e);
         end
      end
      tick();
      e = exp_a(3'd0, 1'b1, 1'b1, 1'b1);
      vectors++;
      if (st_a() !== e) begin
         miscompares++;
         $display("FAIL %s_run_rise edge 17: got %h expected %h", tag, st_a(), e);
      end
      for (int k = 18; k <= 33; k++) begin
         tick();
         e = exp_a(3'((k - 17) % 8), 1'b1, 1'b1, (k < 33));
         vectors++;
         if (st_a() !== e) begin
            miscompares++;
            $display("FAIL %s_hold edge %0d: got %h expected %h", tag, k, st_a(), e);
         end
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; osc_a = 1'b1; ena_a = 1'b1;
      rst_b = 1'b1; osc_b = 1'b1; ena_b = 1'b1;
      tick();
      tick();
      vectors++;
      if (st_a() !== exp_a(3'd0, 1'b0, 1'b0, 1'b1)) begin
         miscompares++;
         $display("FAIL reset_a: got %h expected %h", st_a(), exp_a(3'd0, 1'b0, 1'b0, 1'b1));
      end
      vectors++;
      if (st_b() !== exp_b(2'd0, 1'b0, 1'b0, 1'b1)) begin
         miscompares++;
         $display("FAIL reset_b: got %h expected %h", st_b(), exp_b(2'd0, 1'b0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_startup();
      rst_a = 1'b0;
      startup_sequence("startup");
   endtask

   task automatic test_steady_run();
      logic [11:0] e;
      for (int i = 1; i <= 16; i++) begin
         tick();
         e = exp_a(3'(i % 8), 1'b1, 1'b1, 1'b0);
         vectors++;
         if (st_a() !== e) begin
            miscompares++;
            $display("FAIL steady step %0d: got %h expected %h", i, st_a(), e);
         end
      end
   endtask

   task automatic test_clk_ena_stop();
      logic [11:0] e;
      for (int i = 1; i <= 7; i++) begin
         if (i == 4) ena_a = 1'b0;
         tick();
         e = exp_a(3'(i), 1'b1, 1'b1, 1'b0);
         vectors++;
         if (st_a() !== e) begin
            miscompares++;
            $display("FAIL stop_finish phase %0d: got %h expected %h", i, st_a(), e);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         e = exp_a(3'd0, 1'b0, 1'b1, 1'b0);
         vectors++;
         if (st_a() !== e) begin
            miscompares++;
            $display("FAIL stop_idle step %0d: got %h expected %h", i, st_a(), e);
         end
      end
      ena_a = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         tick();
         e = exp_a(3'(i % 8), 1'b1, 1'b1, 1'b0);
         vectors++;
         if (st_a() !== e) begin
            miscompares++;
            $display("FAIL restart step %0d: got %h expected %h", i, st_a(), e);
         end
      end
   endtask

   task automatic test_osc_drop();
      logic [11:0] e;
      for (int i = 1; i <= 5; i++) tick();
      vectors++;
      if (phase_a !== 3'd5) begin
         miscompares++;
         $display("FAIL osc_pre_phase: got %0d expected 5", phase_a);
      end
      osc_a = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         e = exp_a(3'd0, 1'b0, 1'b0, 1'b1);
         vectors++;
         if (st_a() !== e) begin
            miscompares++;
            $display("FAIL osc_drop step %0d: got %h expected %h", i, st_a(), e);
         end
      end
      osc_a = 1'b1;
      startup_sequence("osc_restore");
   endtask

   task automatic test_async_reset();
      logic [11:0] e;
      for (int i = 1; i <= 6; i++) tick();
      vectors++;
      if (phase_a !== 3'd6) begin
         miscompares++;
         $display("FAIL async_pre_phase: got %0d expected 6", phase_a);
      end
      #2 rst_a = 1'b1;
      #1;
      e = exp_a(3'd0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (st_a() !== e) begin
         miscompares++;
         $display("FAIL async_reset: got %h expected %h", st_a(), e);
      end
      #1 rst_a = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 1 || i == 15 || i == 16) begin
            e = exp_a(3'd0, 1'b0, (i == 16), 1'b1);
            vectors++;
            if (st_a() !== e) begin
               miscompares++;
               $display("FAIL async_resume edge %0d: got %h expected %h", i, st_a(), e);
            end
         end
      end
   endtask

   task automatic test_phases4();
      logic [10:0] e;
      rst_b = 1'b0;
      tick();
      e = exp_b(2'd0, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (st_b() !== e) begin
         miscompares++;
         $display("FAIL p4_stable: got %h expected %h", st_b(), e);
      end
      for (int i = 0; i <= 12; i++) begin
         tick();
         e = exp_b(2'(i % 4), 1'b1, 1'b1, (i < 4));
         vectors++;
         if (st_b() !== e) begin
            miscompares++;
            $display("FAIL p4_run step %0d: got %h expected %h", i, st_b(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_steady_run();
      test_clk_ena_stop();
      test_osc_drop();
      test_async_reset();
      test_phases4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clk_phase_gen.md
CLK_PHASE_GEN -- requirements
Module: clk_phase_gen

Interface
REQ-001 SHALL have parameter PHASES, default 8: phases per machine cycle; legal values are multiples of 4 that are at least 4.
REQ-002 SHALL have parameter STABLE_CYCLES, default 16: OSC_ENA-high CLK cycles required before the oscillator is declared stable; legal range 1..65535.
REQ-003 SHALL have parameter RESET_HOLD, default 2: complete machine cycles for which SYNC_RESET is held after stability; legal values are at least 1.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port OSC_ENA, input, 1 bit: oscillator enable.
REQ-007 SHALL have port CLK_ENA, input, 1 bit: CPU clock run request.
REQ-008 SHALL have port PHASE_IDX, output, $clog2(PHASES) bits: current phase number.
REQ-009 SHALL have port RUN, output, 1 bit: phase counter is advancing.
REQ-010 SHALL have port CYCLE_START, output, 1 bit: high while RUN=1 and PHASE_IDX=0.
REQ-011 SHALL have ports MAIN_CLK_P, DATA_CLK_P, ADR_CLK_P, INC_CLK_P and LATCH_CLK, each output, 1 bit: decoded phase strobes.
REQ-012 SHALL have port OSC_STABLE, output, 1 bit: stability count has been reached.
REQ-013 SHALL have port SYNC_RESET, output, 1 bit: synchronous reset to the CPU.

Function
REQ-014 SHALL hold an internal phase register 0..PHASES-1, output directly on PHASE_IDX.
REQ-015 SHALL advance the phase by 1 per CLK edge only while RUN=1, wrapping from PHASES-1 to 0.
REQ-016 SHALL hold the phase at 0 while RUN=0.
REQ-017 SHALL keep a saturating stability counter wide enough for STABLE_CYCLES.
- Increments on each edge with OSC_ENA=1.
- Clears on any edge with OSC_ENA=0.
REQ-018 SHALL drive OSC_STABLE=1 exactly when the stability counter equals STABLE_CYCLES.
REQ-019 SHALL set RUN on an edge where RUN=0, CLK_ENA=1, OSC_STABLE=1 and OSC_ENA=1.
- The phase stays 0 on that edge.
- The first advance (0 to 1) occurs on the following edge.
REQ-020 SHALL clear RUN only on the edge where the phase goes from PHASES-1 to 0 and (CLK_ENA=0 or OSC_STABLE=0).
- This is a stop at the cycle boundary: a cycle in progress always completes.
REQ-021 SHALL, on any edge with OSC_ENA=0, do all of the following at once, overriding REQ-015 and REQ-020:
- force the phase to 0;
- clear RUN;
- clear the stability counter;
- set SYNC_RESET.
REQ-022 SHALL decode all strobes combinationally from the registered phase and RUN, so there is zero added latency and all strobes are 0 while RUN=0:
- MAIN_CLK_P = RUN and phase < PHASES/2.
- ADR_CLK_P = RUN and phase >= PHASES/2.
- DATA_CLK_P = RUN and PHASES/4 <= phase < 3*PHASES/4.
- INC_CLK_P = RUN and phase = PHASES-1.
- LATCH_CLK = RUN and phase = PHASES/2.
REQ-023 SHALL keep a hold counter that is cleared while OSC_STABLE=0 or RUN=0.
- It increments on each wrap from PHASES-1 to 0 while SYNC_RESET=1.
REQ-024 SHALL clear SYNC_RESET on the wrap edge at which the hold counter reaches RESET_HOLD.
- SYNC_RESET therefore falls aligned to the start of phase 0.
REQ-025 SHALL keep SYNC_RESET at 0 thereafter until RESET or OSC_ENA=0.
- A CLK_ENA stop/restart SHALL NOT reassert SYNC_RESET.
REQ-026 SHALL, when CLK_ENA toggles mid-cycle, take no action until the wrap edge; only the CLK_ENA value sampled on that edge matters.

Reset
REQ-027 SHALL, while RESET=1 and independent of CLK, immediately force the following:
- phase=0, RUN=0, stability counter=0, hold counter=0;
- OSC_STABLE=0, SYNC_RESET=1;
- all strobes and CYCLE_START=0.
REQ-028 SHALL, after RESET deasserts, resume counting from the first CLK edge.
- RESET asserted mid-cycle SHALL abort that cycle without completing it.

Verification
REQ-029 SHALL cover startup with defaults, OSC_ENA=1 and CLK_ENA=1 from reset release:
- OSC_STABLE rises after edge 16.
- RUN rises after edge 17.
- SYNC_RESET falls at the second 7-to-0 wrap after that.
REQ-030 SHALL cover steady run at PHASES=8, with the phase sequence 0..7 repeating:
- MAIN_CLK_P high at phases 0-3, ADR_CLK_P at 4-7, DATA_CLK_P at 2-5.
- LATCH_CLK at 4, INC_CLK_P at 7, CYCLE_START at 0.
REQ-031 SHALL cover a CLK_ENA stop and restart:
- Drop CLK_ENA at phase 3; phases 4..7 still occur, then RUN=0 with the phase held at 0 and all strobes 0.
- Reassert CLK_ENA: RUN=1 after 1 edge, then a full cycle from phase 0; SYNC_RESET stays 0 throughout.
REQ-032 SHALL cover OSC_ENA dropped at phase 5:
- Next edge: phase=0, RUN=0, OSC_STABLE=0, SYNC_RESET=1.
- Restoring OSC_ENA repeats the REQ-029 timing.
REQ-033 SHALL cover RESET pulsed between CLK edges at phase 6:
- All outputs take their reset values before the next edge.
REQ-034 SHALL cover PHASES=4, STABLE_CYCLES=1, RESET_HOLD=1:
- MAIN_CLK_P at phases 0-1, DATA_CLK_P at 1-2, LATCH_CLK at 2, INC_CLK_P at 3.
- SYNC_RESET falls at the first wrap.
